// File: rtl/gate_arb_pkg.sv
// Shared types and widths for the gate-bank arbiter family.
package gate_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   localparam int unsigned GB_IN_W  = 4;
   localparam int unsigned GB_OUT_W = 10;
   localparam int unsigned STAT_W   = 16;

endpackage

// File: rtl/gate_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant for the first set request
// at or above ptr, wrapping past N-1 back to 0.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   logic [2*N-1:0] w_dbl_req;
   logic [N-1:0]   w_rot;
   logic [N-1:0]   w_low;
   logic [2*N-1:0] w_dbl_low;

   // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      w_dbl_req = {req, req} >> ptr;
      w_rot     = w_dbl_req[N-1:0];
      w_low     = w_rot & (~w_rot + N'(1));
      w_dbl_low = {w_low, w_low} << ptr;
      grant     = w_dbl_low[2*N-1:N];
   end

endmodule

// File: rtl/gate_bank_arbiter.sv
// Round-robin arbiter sharing one 4-in/10-out gate bank among N_REQ requesters.
// Optional per-requester grant counters with `define GATE_ARB_STATS_EN.
module gate_bank_arbiter
   import gate_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [GB_IN_W*N_REQ-1:0]    req_operand,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        gb_a,
   output logic                        gb_b,
   output logic                        gb_c,
   output logic                        gb_d,
   input  logic [GB_OUT_W-1:0]         gb_o,
   output logic                        rsp_valid,
   output logic [ID_W-1:0]             rsp_id,
   output logic [GB_OUT_W-1:0]         rsp_data
`ifdef GATE_ARB_STATS_EN
   ,
   output logic [STAT_W*N_REQ-1:0]     stat_grants
`endif
);

   state_t               r_state;
   state_t               w_next_state;
   logic [ID_W-1:0]      r_ptr;
   logic [ID_W-1:0]      r_id;
   logic [GB_IN_W-1:0]   r_gb;
   logic                 r_rsp_valid;
   logic [ID_W-1:0]      r_rsp_id;
   logic [GB_OUT_W-1:0]  r_rsp_data;

   logic [N_REQ-1:0]     w_pick;
   logic [N_REQ-1:0]     w_ready;
   logic                 w_hs;
   logic [ID_W-1:0]      w_win;
   logic [GB_IN_W-1:0]   w_win_op;
   logic [ID_W-1:0]      w_ptr_nxt;

   rr_pick #(
      .N     (N_REQ),
      .PTR_W (ID_W)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_pick)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_ready      = '0;
      case (r_state)
         IDLE: begin
            w_ready = w_pick;
            if (|(req_valid & w_pick)) w_next_state = DRIVE;
         end
         DRIVE: begin
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign w_hs = |(req_valid & w_ready);

   always_comb begin
      w_win    = '0;
      w_win_op = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (w_ready[i]) begin
            w_win    = ID_W'(i);
            w_win_op = req_operand[GB_IN_W*i +: GB_IN_W];
         end
      end
      w_ptr_nxt = (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + ID_W'(1);
   end

   // r_gb doubles as the operand register; it is cleared when DRIVE ends so the bank sees 0 in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gb        <= '0;
         r_id        <= '0;
         r_ptr       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         if (r_state == IDLE) begin
            if (w_hs) begin
               r_gb  <= w_win_op;
               r_id  <= w_win;
               r_ptr <= w_ptr_nxt;
            end
         end else begin
            r_rsp_data  <= gb_o;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_gb        <= '0;
         end
      end
   end

   assign req_ready = w_ready;
   assign gb_a      = r_gb[3];
   assign gb_b      = r_gb[2];
   assign gb_c      = r_gb[1];
   assign gb_d      = r_gb[0];
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;

`ifdef GATE_ARB_STATS_EN
   logic [STAT_W-1:0] r_stat [N_REQ];

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (rst) begin
            r_stat[i] <= '0;
         end else if (req_valid[i] && w_ready[i] && (r_stat[i] != '1)) begin
            r_stat[i] <= r_stat[i] + STAT_W'(1);
         end
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         stat_grants[STAT_W*i +: STAT_W] = r_stat[i];
      end
   end
`endif

endmodule

// File: tb/tb_gate_bank_arbiter.sv
// Self-checking bench for gate_bank_arbiter with a primitive-gate bank on gb_*/gb_o.
module tb_gate_bank_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [15:0] req_operand;
   logic [3:0]  req_ready;
   logic        gb_a, gb_b, gb_c, gb_d;
   logic [9:0]  gb_o;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [9:0]  rsp_data;
`ifdef GATE_ARB_STATS_EN
   logic [63:0] stat_grants;
`endif

   int n_pass;
   int n_total;

   gate_bank_arbiter #(
      .N_REQ (4),
      .ID_W  (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_operand (req_operand),
      .req_ready   (req_ready),
      .gb_a        (gb_a),
      .gb_b        (gb_b),
      .gb_c        (gb_c),
      .gb_d        (gb_d),
      .gb_o        (gb_o),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data)
`ifdef GATE_ARB_STATS_EN
      ,
      .stat_grants (stat_grants)
`endif
   );

   // Gate bank built from primitives; o1 at bit 0.
   and  g1  (gb_o[0], gb_a, gb_b);
   or   g2  (gb_o[1], gb_a, gb_b);
   nand g3  (gb_o[2], gb_a, gb_b);
   nor  g4  (gb_o[3], gb_a, gb_b);
   xor  g5  (gb_o[4], gb_a, gb_b);
   xnor g6  (gb_o[5], gb_a, gb_b);
   not  g7  (gb_o[6], gb_a);
   buf  g8  (gb_o[7], gb_c);
   and  g9  (gb_o[8], gb_c, gb_d);
   xor  g10 (gb_o[9], gb_b, gb_c, gb_d);

   function automatic logic [9:0] gates(input logic [3:0] op);
      logic a, b, c, d;
      a = op[3]; b = op[2]; c = op[1]; d = op[0];
      return {b ^ c ^ d, c & d, c, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = '0;
      req_operand = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_total++;
      if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b required %b", req_ready, 4'b0000);
      else n_pass++;
      n_total++;
      if ({gb_a, gb_b, gb_c, gb_d} !== 4'b0000) $display("FAIL reset_gb: got %b required 0000", {gb_a, gb_b, gb_c, gb_d});
      else n_pass++;
      n_total++;
      if ({rsp_valid, rsp_id, rsp_data} !== 13'd0) $display("FAIL reset_rsp: got %b/%0d/%h required 0/0/000", rsp_valid, rsp_id, rsp_data);
      else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 4'b0001;
      req_operand = 16'h000A;
      #1;
      n_total++;
      if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b required 0001", req_ready);
      else n_pass++;
      @(negedge clk);
      req_valid = '0;
      #1;
      n_total++;
      if ({gb_a, gb_b, gb_c, gb_d} !== 4'b1010 || req_ready !== 4'b0000 || rsp_valid !== 1'b0)
         $display("FAIL single_drive: got gb=%b ready=%b rv=%b required gb=1010 ready=0000 rv=0",
                  {gb_a, gb_b, gb_c, gb_d}, req_ready, rsp_valid);
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== gates(4'b1010) || {gb_a, gb_b, gb_c, gb_d} !== 4'b0000)
         $display("FAIL single_rsp: got rv=%b id=%0d data=%h gb=%b required 1/0/%h/0000",
                  rsp_valid, rsp_id, rsp_data, {gb_a, gb_b, gb_c, gb_d}, gates(4'b1010));
      else n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if (rsp_valid !== 1'b0 || rsp_data !== gates(4'b1010))
         $display("FAIL single_hold: got rv=%b data=%h required 0/%h", rsp_valid, rsp_data, gates(4'b1010));
      else n_pass++;
   endtask

   task automatic test_all_four();
      logic [3:0] ops [4];
      ops[0] = 4'b1010; ops[1] = 4'b0101; ops[2] = 4'b0010; ops[3] = 4'b1111;
      do_reset();
      req_valid = 4'b1111;
      req_operand = {ops[3], ops[2], ops[1], ops[0]};
      for (int k = 0; k < 5; k++) begin
         #1;
         n_total++;
         if (req_ready !== (4'b0001 << (k % 4))) $display("FAIL all4_grant%0d: got %b required %b", k, req_ready, 4'b0001 << (k % 4));
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4) || rsp_data !== gates(ops[(k - 1) % 4]))
               $display("FAIL all4_rsp%0d: got rv=%b id=%0d data=%h required 1/%0d/%h",
                        k, rsp_valid, rsp_id, rsp_data, (k - 1) % 4, gates(ops[(k - 1) % 4]));
            else n_pass++;
         end
         @(negedge clk);
         #1;
         n_total++;
         if ({gb_a, gb_b, gb_c, gb_d} !== ops[k % 4]) $display("FAIL all4_gb%0d: got %b required %b", k, {gb_a, gb_b, gb_c, gb_d}, ops[k % 4]);
         else n_pass++;
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      req_valid = 4'b0100;
      req_operand = 16'h9321;
      #1;
      n_total++;
      if (req_ready !== 4'b0100) $display("FAIL wrap_setup: got %b required 0100", req_ready);
      else n_pass++;
      @(negedge clk);
      req_valid = 4'b1001;
      @(negedge clk);
      #1;
      n_total++;
      if (req_ready !== 4'b1000) $display("FAIL wrap_first: got %b required 1000", req_ready);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      #1;
      n_total++;
      if (req_ready !== 4'b0001 || rsp_id !== 2'd3 || rsp_data !== gates(4'h9))
         $display("FAIL wrap_second: got ready=%b id=%0d data=%h required 0001/3/%h", req_ready, rsp_id, rsp_data, gates(4'h9));
      else n_pass++;
      req_valid = '0;
   endtask

   task automatic test_reset_mid_drive();
      int id0_pulses = 0;
      int id1_pulses = 0;
      do_reset();
      req_valid = 4'b0001;
      req_operand = 16'h000F;
      @(negedge clk);
      req_valid = '0;
      #1;
      n_total++;
      if ({gb_a, gb_b, gb_c, gb_d} !== 4'b1111) $display("FAIL rstmid_drive: got %b required 1111", {gb_a, gb_b, gb_c, gb_d});
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b0010;
      req_operand = 16'h0050;
      #1;
      n_total++;
      if ({gb_a, gb_b, gb_c, gb_d} !== 4'b0000 || rsp_valid !== 1'b0 || req_ready !== 4'b0010)
         $display("FAIL rstmid_idle: got gb=%b rv=%b ready=%b required 0000/0/0010",
                  {gb_a, gb_b, gb_c, gb_d}, rsp_valid, req_ready);
      else n_pass++;
      @(negedge clk);
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (rsp_valid === 1'b1 && rsp_id === 2'd0) id0_pulses++;
         if (rsp_valid === 1'b1 && rsp_id === 2'd1) id1_pulses++;
         @(negedge clk);
      end
      n_total++;
      if (id0_pulses !== 0 || id1_pulses !== 1)
         $display("FAIL rstmid_pulses: got id0=%0d id1=%0d required 0/1", id0_pulses, id1_pulses);
      else n_pass++;
   endtask

   task automatic test_drop();
      int pulses = 0;
      int bad = 0;
      do_reset();
      req_valid = 4'b0010;
      req_operand = 16'h0F50;
      #1;
      n_total++;
      if (req_ready !== 4'b0010) $display("FAIL drop_grant1: got %b required 0010", req_ready);
      else n_pass++;
      @(negedge clk);
      req_valid = 4'b0100;
      #2;
      req_valid = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (req_ready !== 4'b0000 || {gb_a, gb_b, gb_c, gb_d} !== 4'b0000) bad++;
         if (rsp_valid === 1'b1) begin
            pulses++;
            if (rsp_id !== 2'd1 || rsp_data !== gates(4'b0101)) bad++;
         end
      end
      n_total++;
      if (pulses !== 1 || bad !== 0) $display("FAIL drop_nolatch: got pulses=%0d bad=%0d required 1/0", pulses, bad);
      else n_pass++;
   endtask

   task automatic test_random();
      bit         m_drive = 1'b0;
      int         m_ptr = 0;
      logic [3:0] m_op = '0;
      int         m_id = 0;
      logic       m_rv = 1'b0;
      logic [1:0] m_rid = '0;
      logic [9:0] m_rdata = '0;
      int         g;
      logic [3:0] exp_ready;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc != 0) @(negedge clk);
         rst = ($urandom_range(0, 49) == 0);
         req_valid = 4'($urandom_range(0, 15));
         req_operand = 16'($urandom);
         #1;
         g = -1;
         if (!m_drive) begin
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
         end
         exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
         n_total++;
         if (req_ready !== exp_ready) $display("FAIL rand_ready@%0d: got %b required %b", cyc, req_ready, exp_ready);
         else n_pass++;
         n_total++;
         if ({gb_a, gb_b, gb_c, gb_d} !== (m_drive ? m_op : 4'b0000))
            $display("FAIL rand_gb@%0d: got %b required %b", cyc, {gb_a, gb_b, gb_c, gb_d}, m_drive ? m_op : 4'b0000);
         else n_pass++;
         n_total++;
         if (rsp_valid !== m_rv || rsp_id !== m_rid || rsp_data !== m_rdata)
            $display("FAIL rand_rsp@%0d: got %b/%0d/%h required %b/%0d/%h", cyc, rsp_valid, rsp_id, rsp_data, m_rv, m_rid, m_rdata);
         else n_pass++;
         @(posedge clk);
         if (rst) begin
            m_drive = 1'b0; m_ptr = 0; m_op = '0; m_rv = 1'b0; m_rid = '0; m_rdata = '0;
         end else if (m_drive) begin
            m_rv = 1'b1; m_rid = 2'(m_id); m_rdata = gates(m_op); m_drive = 1'b0;
         end else begin
            m_rv = 1'b0;
            if (g >= 0) begin
               m_op = req_operand[4*g +: 4];
               m_id = g;
               m_ptr = (g + 1) % 4;
               m_drive = 1'b1;
            end
         end
      end
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
   endtask

`ifdef GATE_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req_valid = 4'b0110;
      req_operand = 16'h1234;
      repeat (8) @(negedge clk);
      req_valid = 4'b0001;
      repeat (140000) @(negedge clk);
      req_valid = '0;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if (stat_grants !== {16'd0, 16'd2, 16'd2, 16'hFFFF})
         $display("FAIL stats_counts: got %h required %h", stat_grants, {16'd0, 16'd2, 16'd2, 16'hFFFF});
      else n_pass++;
   endtask
`endif

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b1;
      req_valid = '0;
      req_operand = '0;
      test_reset();
      test_single();
      test_all_four();
      test_wrap();
      test_reset_mid_drive();
      test_drop();
      test_random();
`ifdef GATE_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
